// File: rtl/fir_output_requantizer.sv
// fir_output_requantizer
//   Output stage of the FIR filter. Accepts the 40-bit signed full-precision
//   result stream (no backpressure upstream). Each sample is rounded half toward
//   +inf and arithmetically shifted right by SHIFT, then saturated to 16-bit
//   signed. The result is buffered in a DEPTH-entry FIFO behind a valid/ready
//   interface. The path is two register stages followed by the FIFO write, so a
//   sample appears at the FIFO head 3 cycles after its in_valid.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       in_data carries a sample this cycle (cannot be stalled)
//   in_data[39:0]  signed filter output
//   clr_flags      synchronous clear of sat_flag, ovf_flag and drop_cnt
//   out_data[15:0] signed requantized sample at the FIFO head
//   out_valid      FIFO non-empty
//   out_ready      sink takes out_data when out_valid & out_ready
//   sat_flag       sticky: a sample was clipped
//   ovf_flag       sticky: a sample was dropped because the FIFO was full
//   drop_cnt       number of dropped samples, saturating at 0xFFFF
//   fill_level     current FIFO occupancy
module fir_output_requantizer #(
  parameter int SHIFT = 15,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [39:0]              in_data,
  input  logic                     clr_flags,
  output logic [15:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sat_flag,
  output logic                     ovf_flag,
  output logic [15:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  // Rounding constant 2^(SHIFT-1), or 0 when SHIFT is 0.
  localparam logic [40:0] RND_U = (41'd1 << SHIFT) >> 1;
  localparam logic signed [40:0] QMAX = 41'sd32767;
  localparam logic signed [40:0] QMIN = -41'sd32768;
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
  localparam logic [FW-1:0] FILL_ZERO = FW'(0);
  localparam logic [FW-1:0] FILL_ONE  = FW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  // Stage 1 / stage 2 pipeline registers.
  logic               s1_valid_q, s1_valid_d;
  logic signed [40:0] s1_data_q,  s1_data_d;
  logic               s2_valid_q, s2_valid_d;
  logic [15:0]        s2_data_q,  s2_data_d;
  logic               s2_sat_q,   s2_sat_d;

  // FIFO state and sticky status.
  logic [15:0]        mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]      fill_q,   fill_d;
  logic               sat_q,    sat_d;
  logic               ovf_q,    ovf_d;
  logic [15:0]        drop_q,   drop_d;

  logic               full_s, empty_s, pop_s, wr_ok_s, drop_s;
  logic signed [40:0] sum_s;

  // Stage 1: sign-extend to 41 bits so the rounding add can never wrap.
  always_comb begin
    sum_s      = $signed({in_data[39], in_data}) + $signed(RND_U);
    s1_data_d  = sum_s >>> SHIFT;
    s1_valid_d = in_valid;
  end

  // Stage 2: clamp to the 16-bit signed range and remember whether we clipped.
  always_comb begin
    s2_valid_d = s1_valid_q;
    if (s1_data_q > QMAX) begin
      s2_data_d = 16'h7FFF;
      s2_sat_d  = 1'b1;
    end else if (s1_data_q < QMIN) begin
      s2_data_d = 16'h8000;
      s2_sat_d  = 1'b1;
    end else begin
      s2_data_d = s1_data_q[15:0];
      s2_sat_d  = 1'b0;
    end
  end

  // FIFO control: a pop in the same cycle frees a slot for a write into a full FIFO.
  always_comb begin
    full_s   = (fill_q == FILL_FULL);
    empty_s  = (fill_q == FILL_ZERO);
    pop_s    = !empty_s && out_ready;
    wr_ok_s  = s2_valid_q && (!full_s || pop_s);
    drop_s   = s2_valid_q && full_s && !pop_s;
    wr_ptr_d = wr_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({wr_ok_s, pop_s})
      2'b10:   fill_d = fill_q + FILL_ONE;
      2'b01:   fill_d = fill_q - FILL_ONE;
      default: fill_d = fill_q;
    endcase
  end

  // Sticky status: a set event in the same cycle as clr_flags takes priority.
  always_comb begin
    if (s2_valid_q && s2_sat_q) begin
      sat_d = 1'b1;
    end else if (clr_flags) begin
      sat_d = 1'b0;
    end else begin
      sat_d = sat_q;
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_flags) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (drop_s) begin
      if (clr_flags) begin
        drop_d = 16'd1;
      end else if (drop_q == 16'hFFFF) begin
        drop_d = drop_q;
      end else begin
        drop_d = drop_q + 16'd1;
      end
    end else if (clr_flags) begin
      drop_d = 16'd0;
    end else begin
      drop_d = drop_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= 41'sd0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= 16'd0;
      s2_sat_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_sat_q   <= s2_sat_d;
    end
  end

  // FIFO storage; cleared on reset so out_data reads 0 while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'd0;
      end
    end else if (wr_ok_s) begin
      mem_q[wr_ptr_q] <= s2_data_q;
    end
  end

  // FIFO pointers, occupancy and sticky status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= FILL_ZERO;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= 16'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      sat_q    <= sat_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  assign out_data   = mem_q[rd_ptr_q];
  assign out_valid  = !empty_s;
  assign sat_flag   = sat_q;
  assign ovf_flag   = ovf_q;
  assign drop_cnt   = drop_q;
  assign fill_level = fill_q;

endmodule

// File: tb/tb_fir_output_requantizer.sv
// Directed bench for fir_output_requantizer: one instance at SHIFT=15 and one
// at SHIFT=0, both DEPTH=8, sharing clock and reset.
module tb_fir_output_requantizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, clr_flags, out_ready;
  logic [39:0] in_data;
  logic [15:0] out_data, drop_cnt;
  logic        out_valid, sat_flag, ovf_flag;
  logic [3:0]  fill_level;

  logic        in_valid0, clr_flags0, out_ready0;
  logic [39:0] in_data0;
  logic [15:0] out_data0, drop_cnt0;
  logic        out_valid0, sat_flag0, ovf_flag0;
  logic [3:0]  fill_level0;

  int checks = 0;
  int failures = 0;
  longint exp_q[$];

  always #5 clk = ~clk;

  fir_output_requantizer #(.SHIFT(15), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .clr_flags(clr_flags), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sat_flag(sat_flag), .ovf_flag(ovf_flag),
    .drop_cnt(drop_cnt), .fill_level(fill_level)
  );

  fir_output_requantizer #(.SHIFT(0), .DEPTH(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_data(in_data0),
    .clr_flags(clr_flags0), .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(out_ready0), .sat_flag(sat_flag0), .ovf_flag(ovf_flag0),
    .drop_cnt(drop_cnt0), .fill_level(fill_level0)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated sample through the SHIFT=15 instance, checking latency and value.
  task automatic single(input string tag, input longint din, input longint exp);
    in_valid = 1'b1;
    in_data  = din[39:0];
    tick();
    in_valid = 1'b0;
    tick();
    check({tag, "_not_yet"}, longint'(out_valid), 0);
    tick();
    check({tag, "_valid"}, longint'(out_valid), 1);
    check({tag, "_data"}, longint'($signed(out_data)), exp);
  endtask

  // Compare the SHIFT=0 head against the reference queue (pop happens at next edge).
  task automatic check_head0(input string tag);
    longint e;
    if (out_valid0) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(tag, longint'($signed(out_data0)), e);
      end else begin
        check({tag, "_unexpected"}, 1, 0);
      end
    end
  endtask

  initial begin
    logic [63:0]        r64;
    logic signed [39:0] d40;
    longint             v;

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 40'd0; clr_flags = 1'b0; out_ready = 1'b1;
    in_valid0 = 1'b0; in_data0 = 40'd0; clr_flags0 = 1'b0; out_ready0 = 1'b1;
    #12;
    check("reset_valid", longint'(out_valid), 0);
    check("reset_fill", longint'(fill_level), 0);
    check("reset_data", longint'(out_data), 0);
    check("reset_drop", longint'(drop_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Rounding half toward +inf.
    single("rnd_pos_half", 64'sd16384, 1);
    single("rnd_neg_half", -64'sd16384, 0);
    single("rnd_below_half", 64'sd16383, 0);
    check("rnd_no_sat", longint'(sat_flag), 0);

    // Saturation and flag clear.
    single("sat_pos", 64'sd2147483648, 32767);
    check("sat_flag_set", longint'(sat_flag), 1);
    single("sat_neg", -64'sd2147483648, -32768);
    tick();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("sat_flag_clr", longint'(sat_flag), 0);

    // Backpressure: 10 samples into 8 slots.
    out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      in_valid = 1'b1;
      in_data  = 40'(k * 32768);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("bp_fill", longint'(fill_level), 8);
    check("bp_drop", longint'(drop_cnt), 2);
    check("bp_ovf", longint'(ovf_flag), 1);
    check("bp_head_hold", longint'(out_data), 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("bp_valid", longint'(out_valid), 1);
      check("bp_order", longint'($signed(out_data)), i);
      tick();
    end
    check("bp_empty", longint'(out_valid), 0);

    // Full FIFO with a pop and a write on the same edge.
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("clr_ovf", longint'(ovf_flag), 0);
    check("clr_drop", longint'(drop_cnt), 0);
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = 40'(k * 32768);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("fp_full", longint'(fill_level), 8);
    in_valid = 1'b1;
    in_data  = 40'(9 * 32768);
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("fp_fill_stays", longint'(fill_level), 8);
    check("fp_no_drop", longint'(drop_cnt), 0);
    check("fp_no_ovf", longint'(ovf_flag), 0);
    out_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      check("fp_order", longint'($signed(out_data)), i);
      tick();
    end
    check("fp_empty", longint'(out_valid), 0);

    // Reset with 5 buffered and 2 in flight.
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1;
      in_data  = (k == 5) ? 40'd2147483648 : 40'((20 + k) * 32768);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("mr_fill5", longint'(fill_level), 5);
    check("mr_sat_before", longint'(sat_flag), 1);
    in_valid = 1'b1;
    in_data  = 40'(30 * 32768);
    tick();
    in_data  = 40'(31 * 32768);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mr_valid", longint'(out_valid), 0);
    check("mr_fill", longint'(fill_level), 0);
    check("mr_sat", longint'(sat_flag), 0);
    check("mr_ovf", longint'(ovf_flag), 0);
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("mr_no_ghost", longint'(out_valid), 0);
    single("mr_first", 64'sd229376, 7);
    tick();
    check("mr_drained", longint'(out_valid), 0);

    // SHIFT=0 instance: directed samples.
    in_valid0 = 1'b1;
    in_data0  = 40'd40000;
    tick();
    in_valid0 = 1'b0;
    tick(); tick();
    check("s0_sat_valid", longint'(out_valid0), 1);
    check("s0_sat_data", longint'($signed(out_data0)), 32767);
    check("s0_sat_flag", longint'(sat_flag0), 1);
    in_valid0 = 1'b1;
    in_data0  = 40'hFF_FFFF_FFFB;
    tick();
    in_valid0 = 1'b0;
    tick(); tick();
    check("s0_neg5", longint'($signed(out_data0)), -5);
    tick();

    // SHIFT=0 instance: random stream against a clamp reference.
    for (int cyc = 0; cyc < 1400; cyc++) begin
      check_head0("s0_rand");
      in_valid0 = ($urandom_range(0, 9) < 7);
      if (in_valid0) begin
        r64 = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 0) begin
          r64 = 64'($signed(32'($urandom_range(0, 80000))) - 64'sd40000);
        end
        d40 = r64[39:0];
        v = d40;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        exp_q.push_back(v);
        in_data0 = r64[39:0];
      end
      tick();
    end
    in_valid0 = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      check_head0("s0_drain");
      tick();
    end
    check("s0_queue_empty", longint'(exp_q.size()), 0);
    check("s0_no_drop", longint'(drop_cnt0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
